// File: rtl/ps2_key_decoder.sv
`timescale 1ns/1ps
// PS/2 keyboard receiver: turns make codes into 5-bit game commands, drops break sequences.
// Latency: command appears 4 CLOCK_50 cycles after the first sync flop captures the stop-bit fall.
// Backpressure: none; the keyboard cannot be stalled, so every command is a single-cycle pulse.
// Optional build macro PS2_PARITY_CHECK_EN: validate odd parity and stop bit before decoding.
module ps2_key_decoder #(
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter logic [4:0] IDLE_CODE      = 5'd31
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [4:0] KEY_PRESSED,
    output logic       key_valid,
    output logic       frame_err
);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic        clk_s1_q, clk_s2_q, clk_s3_q;
    logic        dat_s1_q, dat_s2_q;
    logic [3:0]  bit_cnt_q;
    logic [9:0]  shift_q;      // {stop, parity, data[7:0]} once the frame is complete
    logic [15:0] tmo_cnt_q;
    logic        err0_q, tmo0_q;           // error raised by IDLE/RECV, delayed to line up with DONE
    logic        err1_q, tmo1_q;           // error presented to the decoder stage
    logic        byte_vld_q;
    logic [7:0]  byte_q;
    logic        ext_q, brk_q;

    logic        clk_fall, clk_edge, frame_ok;
    logic        hit_d;
    logic [4:0]  code_d;

    assign clk_fall = clk_s3_q & ~clk_s2_q;
    assign clk_edge = clk_s3_q ^ clk_s2_q;

    // Frame validation applied in DONE
    always_comb begin
`ifdef PS2_PARITY_CHECK_EN
        frame_ok = (^shift_q[8:0]) & shift_q[9];
`else
        frame_ok = 1'b1;
`endif
    end

    // Synchronisers, receive FSM, timeout and hand-off to the decoder stage
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_s3_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            state_q    <= S_IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 10'd0;
            tmo_cnt_q  <= 16'd0;
            err0_q     <= 1'b0;
            tmo0_q     <= 1'b0;
            err1_q     <= 1'b0;
            tmo1_q     <= 1'b0;
            byte_vld_q <= 1'b0;
            byte_q     <= 8'd0;
        end else begin
            clk_s1_q   <= PS2_CLK;
            clk_s2_q   <= clk_s1_q;
            clk_s3_q   <= clk_s2_q;
            dat_s1_q   <= PS2_DAT;
            dat_s2_q   <= dat_s1_q;
            err0_q     <= 1'b0;
            tmo0_q     <= 1'b0;
            err1_q     <= err0_q;
            tmo1_q     <= tmo0_q;
            byte_vld_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    tmo_cnt_q <= 16'd0;
                    if (clk_fall) begin
                        if (!dat_s2_q) begin
                            state_q   <= S_RECV;
                            bit_cnt_q <= 4'd0;
                        end else begin
                            err0_q <= 1'b1;
                        end
                    end
                end
                S_RECV: begin
                    if (clk_fall) begin
                        shift_q   <= {dat_s2_q, shift_q[9:1]};
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd9) begin
                            state_q <= S_DONE;
                        end
                    end
                    if (clk_edge) begin
                        tmo_cnt_q <= 16'd0;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        tmo_cnt_q <= 16'd0;
                        err0_q    <= 1'b1;
                        tmo0_q    <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    end
                end
                default: begin
                    byte_q <= shift_q[7:0];
                    if (frame_ok) begin
                        byte_vld_q <= 1'b1;
                    end else begin
                        err1_q <= 1'b1;
                    end
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Keymap lookup on (extended prefix, byte)
    always_comb begin
        hit_d  = 1'b1;
        code_d = IDLE_CODE;
        case ({ext_q, byte_q})
            9'h175: code_d = 5'd0;
            9'h172: code_d = 5'd1;
            9'h16B: code_d = 5'd2;
            9'h174: code_d = 5'd3;
            9'h01D: code_d = 5'd4;
            9'h01B: code_d = 5'd5;
            9'h01C: code_d = 5'd6;
            9'h023: code_d = 5'd7;
            9'h043: code_d = 5'd8;
            9'h042: code_d = 5'd9;
            9'h03B: code_d = 5'd10;
            9'h04B: code_d = 5'd11;
            9'h075: code_d = 5'd12;
            9'h073: code_d = 5'd13;
            9'h06B: code_d = 5'd14;
            9'h074: code_d = 5'd15;
            9'h029: code_d = 5'd16;
            default: hit_d = 1'b0;
        endcase
    end

    // Prefix tracking and registered command/error outputs
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            KEY_PRESSED <= IDLE_CODE;
            key_valid   <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            KEY_PRESSED <= IDLE_CODE;
            key_valid   <= 1'b0;
            frame_err   <= 1'b0;
            if (err1_q) begin
                frame_err <= 1'b1;
                if (tmo1_q) begin
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                end
            end else if (byte_vld_q) begin
                if (byte_q == 8'hE0) begin
                    ext_q <= 1'b1;
                end else if (byte_q == 8'hF0) begin
                    brk_q <= 1'b1;
                end else if (brk_q) begin
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                end else begin
                    ext_q <= 1'b0;
                    if (hit_d) begin
                        KEY_PRESSED <= code_d;
                        key_valid   <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
`timescale 1ns/1ps
// Directed bench for ps2_key_decoder: bit-banged PS/2 frames, monitor records every
// command pulse and error pulse, expectations are hand-computed keymap codes.
module tb_ps2_key_decoder;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic       PS2_CLK  = 1'b1;
    logic       PS2_DAT  = 1'b1;
    logic [4:0] KEY_PRESSED;
    logic       key_valid;
    logic       frame_err;

    localparam int HP = 20;   // PS/2 half bit time in CLOCK_50 cycles

    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   cyc      = 0;
    int   fall_cyc = 0;
    int   kv_cyc   = 0;
    int   err_cnt  = 0;
    int   viol     = 0;
    int   codes[$];
    logic kv_prev  = 1'b0;

    ps2_key_decoder dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .PS2_CLK     (PS2_CLK),
        .PS2_DAT     (PS2_DAT),
        .KEY_PRESSED (KEY_PRESSED),
        .key_valid   (key_valid),
        .frame_err   (frame_err)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge
    always @(negedge CLOCK_50) begin
        if (key_valid === 1'b1) begin
            codes.push_back(int'(KEY_PRESSED));
            kv_cyc = cyc;
            if (kv_prev) viol++;
            if (frame_err === 1'b1) viol++;
        end else if (!reset && KEY_PRESSED !== 5'd31) begin
            viol++;
        end
        if (frame_err === 1'b1) err_cnt++;
        kv_prev = (key_valid === 1'b1);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic ps2_bit(input logic b);
        PS2_DAT = b;
        wait_clk(HP / 2);
        PS2_CLK  = 1'b0;
        fall_cyc = cyc;
        wait_clk(HP);
        PS2_CLK = 1'b1;
        wait_clk(HP / 2);
    endtask

    // Sends the first nbits of a frame; bad_par inverts the odd-parity bit
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
        PS2_DAT = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 11);
        wait_clk(30);
    endtask

    task automatic clear_mon();
        codes.delete();
        err_cnt = 0;
    endtask

    task automatic expect_keys(input string tag, input int n, input int code, input int errs);
        check({tag, ".pulses"}, codes.size(), n);
        if (n > 0 && codes.size() > 0) check({tag, ".code"}, codes[codes.size() - 1], code);
        check({tag, ".err"}, err_cnt, errs);
        clear_mon();
    endtask

    logic [7:0] map_byte [13] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h43, 8'h42, 8'h3B,
                                  8'h4B, 8'h75, 8'h73, 8'h6B, 8'h74, 8'h29};
    int         map_code [13] = '{4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
    logic [7:0] ext_byte [4]  = '{8'h75, 8'h72, 8'h6B, 8'h74};

    initial begin
        wait_clk(5);
        check("rst.key", int'(KEY_PRESSED), 31);
        check("rst.valid", int'(key_valid), 0);
        check("rst.err", int'(frame_err), 0);
        reset = 1'b0;
        wait_clk(5);
        clear_mon();

        // Make code; stop fall driven at cyc N, captured at N+1, command at N+5
        send(8'h1D);
        check("lat", kv_cyc - fall_cyc, 5);
        expect_keys("make_1D", 1, 4, 0);

        // Typematic repeat re-emits
        send(8'h1D);
        send(8'h1D);
        expect_keys("repeat", 2, 4, 0);

        // Full non-extended keymap
        foreach (map_byte[i]) begin
            send(map_byte[i]);
            expect_keys($sformatf("map_%02h", map_byte[i]), 1, map_code[i], 0);
        end

        // Arrow keys via E0 prefix; E0 alone is silent
        foreach (ext_byte[i]) begin
            send(8'hE0);
            expect_keys($sformatf("e0_only_%0d", i), 0, 0, 0);
            send(ext_byte[i]);
            expect_keys($sformatf("arrow_%02h", ext_byte[i]), 1, i, 0);
        end

        // Break suppression, then normal key
        send(8'hF0);
        send(8'h1D);
        expect_keys("break", 0, 0, 0);
        send(8'h29);
        expect_keys("space", 1, 16, 0);

        // Extended break clears both prefixes
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        expect_keys("ext_break", 0, 0, 0);
        send(8'h75);
        expect_keys("after_ext_break", 1, 12, 0);

        // Unmapped byte
        send(8'h15);
        expect_keys("unmapped", 0, 0, 0);

        // Corrupt parity
        send_frame(8'h1D, 1'b1, 11);
        wait_clk(30);
`ifdef PS2_PARITY_CHECK_EN
        expect_keys("bad_parity", 0, 0, 1);
`else
        expect_keys("bad_parity", 1, 4, 0);
`endif

        // Start bit of 1
        ps2_bit(1'b1);
        wait_clk(30);
        expect_keys("bad_start", 0, 0, 1);
        send(8'h23);
        expect_keys("after_bad_start", 1, 7, 0);

        // Timeout after 5 bits; E0 prefix must be dropped
        send(8'hE0);
        send_frame(8'h1D, 1'b0, 5);
        wait_clk(50100);
        expect_keys("timeout", 0, 0, 1);
        send(8'h75);
        expect_keys("after_timeout", 1, 12, 0);
        send(8'h23);
        expect_keys("timeout_next", 1, 7, 0);

        // Reset mid-frame
        send_frame(8'h43, 1'b0, 6);
        reset = 1'b1;
        wait_clk(2);
        check("midrst.key", int'(KEY_PRESSED), 31);
        check("midrst.valid", int'(key_valid), 0);
        check("midrst.err", int'(frame_err), 0);
        reset = 1'b0;
        wait_clk(5);
        expect_keys("midrst", 0, 0, 0);
        send(8'h43);
        expect_keys("after_midrst", 1, 8, 0);

        check("pulse_shape", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #10ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
